// File: rtl/cpu_pkg.sv
// Shared CPU types: branch condition codes, branch-unit FSM states and the condition evaluator.
package cpu_pkg;

  typedef enum logic [2:0] {
    AL = 3'd0,
    EQ = 3'd1,
    NE = 3'd2,
    LT = 3'd3,
    GE = 3'd4,
    GT = 3'd5,
    LE = 3'd6,
    NV = 3'd7
  } cond_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bcu_state_e;

  // Branch taken decision from the N/Z flags.
  function automatic logic cond_taken(cond_e c, logic n, logic z);
    logic t;
    t = 1'b0;
    unique case (c)
      AL: t = 1'b1;
      EQ: t = z;
      NE: t = ~z;
      LT: t = n;
      GE: t = ~n;
      GT: t = ~n & ~z;
      LE: t = n | z;
      NV: t = 1'b0;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/flag_pending_counter.sv
// Saturating up/down count of outstanding flag writes; err latches any over/underflow until reset.
module flag_pending_counter #(
  parameter int unsigned PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              err
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: begin
          if (cnt == CNT_MAX) err <= 1'b1;
          else                cnt <= cnt + PEND_W'(1);
        end
        2'b01: begin
          if (cnt == '0) err <= 1'b1;
          else           cnt <= cnt - PEND_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Conditional-branch resolver: holds one branch until no flag writes are pending, then
// evaluates it against the registered N/Z flags and pulses the result to fetch.
module branch_cond_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              n_i,
  input  logic              z_i,
  input  logic              flag_set_i,
  input  logic              flag_done_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        cond_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              flush_i,
  output logic              resolve_o,
  output logic              taken_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              err_o
);

  bcu_state_e        state;
  cond_e             cond_q;
  logic [ADDR_W-1:0] target_q;
  logic [PEND_W-1:0] pend_cnt;

  flag_pending_counter #(
    .PEND_W(PEND_W)
  ) u_pend (
    .clk (clk),
    .rst (rst),
    .inc (flag_set_i),
    .dec (flag_done_i),
    .cnt (pend_cnt),
    .err (err_o)
  );

  // Evaluation uses the registered count so a same-cycle final flag write is seen first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cond_q    <= AL;
      target_q  <= '0;
      ready_o   <= 1'b1;
      resolve_o <= 1'b0;
      taken_o   <= 1'b0;
      target_o  <= '0;
    end else begin
      resolve_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            cond_q   <= cond_e'(cond_i);
            target_q <= target_i;
            state    <= WAIT;
            ready_o  <= 1'b0;
          end
        end
        WAIT: begin
          if (flush_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
          end else if (pend_cnt == '0) begin
            taken_o   <= cond_taken(cond_q, n_i, z_i);
            target_o  <= target_q;
            resolve_o <= 1'b1;
            state     <= IDLE;
            ready_o   <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: condition table sweep plus latency, flush,
// reset and pending-counter corner sequences, with a resolve scoreboard.
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        n_i, z_i, flag_set_i, flag_done_i, valid_i, flush_i;
  logic        ready_o, resolve_o, taken_o, err_o;
  logic [2:0]  cond_i;
  logic [31:0] target_i, target_o;

  always #5 clk = ~clk;

  branch_cond_unit #(.ADDR_W(32), .PEND_W(3)) dut (
    .clk(clk), .rst(rst), .n_i(n_i), .z_i(z_i),
    .flag_set_i(flag_set_i), .flag_done_i(flag_done_i),
    .valid_i(valid_i), .ready_o(ready_o), .cond_i(cond_i), .target_i(target_i),
    .flush_i(flush_i), .resolve_o(resolve_o), .taken_o(taken_o),
    .target_o(target_o), .err_o(err_o)
  );

  typedef struct {
    logic [2:0] cond;
    logic       n;
    logic       z;
    logic       taken;
  } vec_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  vec_t vecs[32];
  // bit {n,z} of each entry: taken for that flag combination
  logic [3:0] exp_tab[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    step();
    step();
    rst = 1'b1;
  endtask

  // Drive one request through the accept edge and record the expected result.
  task automatic send(input logic [2:0] c, input logic [31:0] t, input logic n, input logic z,
                      input logic exp_taken);
    valid_i = 1'b1; cond_i = c; target_i = t; n_i = n; z_i = z;
    exp_q.push_back({exp_taken, t});
    step();
    valid_i = 1'b0;
    check("ready_low_in_wait", 32'(ready_o), 32'd0);
  endtask

  // Wait (bounded) for the resolve pulse, compare against the scoreboard and latency.
  task automatic wait_resolve(input int lat_exp, input string name);
    int   lat;
    exp_t e;
    lat = 0;
    while (!resolve_o && lat < 20) begin
      step();
      lat++;
    end
    if (!resolve_o) begin
      check({name, "_timeout"}, 32'(resolve_o), 32'd1);
    end else if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_latency"}, 32'(lat), 32'(lat_exp));
      check({name, "_taken"}, 32'(taken_o), 32'(e.taken));
      check({name, "_target"}, target_o, e.target);
      check({name, "_ready"}, 32'(ready_o), 32'd1);
      step();
      check({name, "_pulse_width"}, 32'(resolve_o), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] row;
    exp_tab[0] = 4'b1111; // AL
    exp_tab[1] = 4'b1010; // EQ
    exp_tab[2] = 4'b0101; // NE
    exp_tab[3] = 4'b1100; // LT
    exp_tab[4] = 4'b0011; // GE
    exp_tab[5] = 4'b0001; // GT
    exp_tab[6] = 4'b1110; // LE
    exp_tab[7] = 4'b0000; // NV
    for (int i = 0; i < 32; i++) begin
      vecs[i].cond  = 3'(i / 4);
      vecs[i].n     = i[1];
      vecs[i].z     = i[0];
      row           = exp_tab[i / 4];
      vecs[i].taken = row[i % 4];
    end

    n_i = 0; z_i = 0; flag_set_i = 0; flag_done_i = 0; valid_i = 0; flush_i = 0;
    cond_i = 0; target_i = 0;
    do_reset();

    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_resolve", 32'(resolve_o), 32'd0);
    check("rst_taken", 32'(taken_o), 32'd0);
    check("rst_target", target_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_pend", 32'(dut.pend_cnt), 32'd0);

    // EQ and NE with Z set, no pending flags
    send(3'd1, 32'h100, 1'b0, 1'b1, 1'b1);
    wait_resolve(1, "eq");
    send(3'd2, 32'h100, 1'b0, 1'b1, 1'b0);
    wait_resolve(1, "ne");
    send(3'd1, 32'h100, 1'b0, 1'b1, 1'b1);
    wait_resolve(1, "eq2");

    // Asynchronous reset mid-WAIT with two writes pending
    flag_set_i = 1; step(); step(); flag_set_i = 0;
    valid_i = 1; cond_i = 3'd0; target_i = 32'h55; step(); valid_i = 0;
    check("midwait_pend", 32'(dut.pend_cnt), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_taken", 32'(taken_o), 32'd0);
    check("midrst_target", target_o, 32'd0);
    check("midrst_pend", 32'(dut.pend_cnt), 32'd0);
    step(); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_resolve", 32'(resolve_o), 32'd0);
    end

    // GT waits on two pending flag writes
    flag_set_i = 1; step(); step(); flag_set_i = 0;
    exp_q.push_back({1'b1, 32'h200});
    valid_i = 1; cond_i = 3'd5; target_i = 32'h200; n_i = 1; z_i = 1; step(); valid_i = 0;
    check("gt_ready0", 32'(ready_o), 32'd0);
    step(); check("gt_ready1", 32'(ready_o), 32'd0);
    flag_done_i = 1; step(); flag_done_i = 0;
    check("gt_ready2", 32'(ready_o), 32'd0);
    check("gt_pend1", 32'(dut.pend_cnt), 32'd1);
    step(); check("gt_ready3", 32'(ready_o), 32'd0);
    flag_done_i = 1; n_i = 0; z_i = 0; step(); flag_done_i = 0;
    check("gt_no_early_resolve", 32'(resolve_o), 32'd0);
    check("gt_ready4", 32'(ready_o), 32'd0);
    wait_resolve(1, "gt");

    // Full condition-code by flags sweep
    for (int i = 0; i < 32; i++) begin
      send(vecs[i].cond, 32'h1000 + 32'(i * 4), vecs[i].n, vecs[i].z, vecs[i].taken);
      wait_resolve(1, $sformatf("sweep%0d", i));
    end

    // Flush a waiting branch, then resolve a new one normally
    flag_set_i = 1; step(); flag_set_i = 0;
    valid_i = 1; cond_i = 3'd0; target_i = 32'h300; step(); valid_i = 0;
    flush_i = 1; step(); flush_i = 0;
    check("flush_ready", 32'(ready_o), 32'd1);
    check("flush_no_resolve", 32'(resolve_o), 32'd0);
    flag_done_i = 1; step(); flag_done_i = 0;
    check("flush_no_resolve2", 32'(resolve_o), 32'd0);
    check("flush_pend0", 32'(dut.pend_cnt), 32'd0);
    send(3'd6, 32'h400, 1'b1, 1'b0, 1'b1);
    wait_resolve(1, "after_flush");

    // Underflow at zero
    flag_done_i = 1; step(); flag_done_i = 0;
    check("under_err", 32'(err_o), 32'd1);
    check("under_pend", 32'(dut.pend_cnt), 32'd0);
    step(); step();
    check("under_sticky", 32'(err_o), 32'd1);
    do_reset();
    check("err_cleared", 32'(err_o), 32'd0);

    // Overflow: eight increments saturate at seven
    flag_set_i = 1;
    for (int i = 0; i < 8; i++) step();
    flag_set_i = 0;
    check("over_pend", 32'(dut.pend_cnt), 32'd7);
    check("over_err", 32'(err_o), 32'd1);
    flag_set_i = 1; flag_done_i = 1; step(); flag_set_i = 0; flag_done_i = 0;
    check("both_pend", 32'(dut.pend_cnt), 32'd7);
    check("over_sticky", 32'(err_o), 32'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
